sm_debug_ctrl: RTL and testbench

- Board-level execution and debug controller for the schoolRISCV core.
- Debounces the two push-buttons and runs a HALT/RUN state machine.
- Produces the core's clock-enable pulses: single-step, or free-run at a programmable rate.
- Sequences the register-file debug read port (regAddr/regData) and drives a byte of the selected register to the LEDs.
- Sits between the board top (keys, switches, LEDs) and sm_top, and replaces the fixed divider/enable wiring.

---
 rtl/sm_debug_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sm_debug_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sm_debug_ctrl.sv
// -----------------------------------------------------------------------------
// sm_debug_ctrl
//   Board-level execution and debug controller for the schoolRISCV core.
//   Debounces the mode and step keys and runs a HALT/RUN state machine that
//   produces the core's clock-enable pulses: one pulse per step press in HALT,
//   or one pulse every 2^runDivide cycles in RUN. It also drives the register
//   file debug read port and shows one byte of the selected register.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   btnMode_n  raw mode key, active-low, asynchronous to clk
//   btnStep_n  raw step key, active-low, asynchronous to clk
//   runDivide  RUN rate exponent (pulse every 2^runDivide cycles)
//   regSel     register index requested for display
//   byteSel    byte of regData to display
//   regData    debug read data from the core, combinational in regAddr
//   cpuClkEn   one-cycle core enable
//   running    1 in RUN, 0 in HALT
//   stepCount  number of cpuClkEn pulses issued (wraps)
//   regAddr    debug read address to the core
//   ledData    selected byte of the selected register
// -----------------------------------------------------------------------------
module sm_debug_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DIV_W           = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btnMode_n,
  input  logic        btnStep_n,
  input  logic [3:0]  runDivide,
  input  logic [4:0]  regSel,
  input  logic [1:0]  byteSel,
  input  logic [31:0] regData,
  output logic        cpuClkEn,
  output logic        running,
  output logic [15:0] stepCount,
  output logic [4:0]  regAddr,
  output logic [7:0]  ledData
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int               MAX_RATE = DIV_W - 1;

  typedef enum logic {ST_HALT, ST_RUN} state_t;

  // Key index 0 = mode, 1 = step. All levels are active-low (1 = released).
  logic [1:0]       w_raw;
  logic [1:0]       r_sync0;
  logic [1:0]       r_sync1;
  logic [1:0]       r_db;
  logic [1:0]       r_press;
  logic [CNT_W-1:0] r_cnt [2];

  assign w_raw = {btnStep_n, btnMode_n};

  // Two-flop synchronizer followed by a stability counter per key. The
  // debounced level only follows the synchronized level after it has
  // disagreed for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 2'b11;
      r_sync1 <= 2'b11;
      r_db    <= 2'b11;
      r_press <= 2'b00;
      for (int k = 0; k < 2; k++) r_cnt[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling the pre-edge
      // values, so r_sync1 gets last cycle's r_sync0, not this cycle's.
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      for (int k = 0; k < 2; k++) begin
        r_press[k] <= 1'b0;
        if (r_sync1[k] == r_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == CNT_LAST) begin
          r_cnt[k]   <= '0;
          r_db[k]    <= r_sync1[k];
          // Only the released->pressed flip produces an event.
          r_press[k] <= ~r_sync1[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  logic w_mode_press;
  logic w_step_press;
  assign w_mode_press = r_press[0];
  assign w_step_press = r_press[1];

  // Rate exponent clamped so the mask never exceeds the divider width.
  logic [3:0]       w_rate;
  logic [DIV_W-1:0] w_mask;
  assign w_rate = (int'(runDivide) > MAX_RATE) ? 4'(MAX_RATE) : runDivide;
  assign w_mask = DIV_W'((32'd1 << w_rate) - 32'd1);

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_en;
  logic             w_en_next;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_div_next   = r_div;
    w_en_next    = 1'b0;
    case (r_state)
      ST_HALT: begin
        // Mode wins over a same-cycle step: enter RUN without stepping.
        if (w_mode_press) begin
          w_next_state = ST_RUN;
          w_div_next   = '0;
        end else if (w_step_press) begin
          w_en_next = 1'b1;
        end
      end
      ST_RUN: begin
        w_div_next = r_div + DIV_W'(1);
        if (w_mode_press) begin
          w_next_state = ST_HALT;
        end else begin
          w_en_next = ((r_div & w_mask) == w_mask);
        end
      end
      default: w_next_state = ST_HALT;
    endcase
  end

  logic        r_running;
  logic [15:0] r_step_cnt;
  logic [4:0]  r_reg_addr;
  logic [7:0]  r_led;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_HALT;
      r_div      <= '0;
      r_en       <= 1'b0;
      r_running  <= 1'b0;
      r_step_cnt <= '0;
      r_reg_addr <= '0;
      r_led      <= '0;
    end else begin
      r_state    <= w_next_state;
      r_div      <= w_div_next;
      r_en       <= w_en_next;
      r_running  <= (w_next_state == ST_RUN);
      if (r_en) r_step_cnt <= r_step_cnt + 16'd1;
      r_reg_addr <= regSel;
      r_led      <= regData[{byteSel, 3'b000} +: 8];
    end
  end

  // Gated with rst so a pulse in flight is dropped in the reset cycle itself.
  assign cpuClkEn  = r_en & ~rst;
  assign running   = r_running;
  assign stepCount = r_step_cnt;
  assign regAddr   = r_reg_addr;
  assign ledData   = r_led;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm_debug_ctrl
//   Directed self-checking bench for sm_debug_ctrl with DEBOUNCE_CYCLES=4.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sm_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnMode_n;
  logic        btnStep_n;
  logic [3:0]  runDivide;
  logic [4:0]  regSel;
  logic [1:0]  byteSel;
  logic [31:0] regData;
  logic        cpuClkEn;
  logic        running;
  logic [15:0] stepCount;
  logic [4:0]  regAddr;
  logic [7:0]  ledData;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always #5 clk = ~clk;

  sm_debug_ctrl #(.DEBOUNCE_CYCLES(4), .DIV_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .btnMode_n (btnMode_n),
    .btnStep_n (btnStep_n),
    .runDivide (runDivide),
    .regSel    (regSel),
    .byteSel   (byteSel),
    .regData   (regData),
    .cpuClkEn  (cpuClkEn),
    .running   (running),
    .stepCount (stepCount),
    .regAddr   (regAddr),
    .ledData   (ledData)
  );

  // Register file model: x0 reads 0, x5 holds a known pattern.
  always_comb begin
    regData = 32'h0F0F_0F0F;
    if (regAddr == 5'd0) regData = 32'h0000_0000;
    else if (regAddr == 5'd5) regData = 32'hA1B2_C3D4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_count();
    tick();
    if (cpuClkEn === 1'b1) pulses++;
  endtask

  initial begin
    int first;
    int base;
    int k;
    logic [15:0] s;

    rst       = 1'b1;
    btnMode_n = 1'b1;
    btnStep_n = 1'b1;
    runDivide = 4'd0;
    regSel    = 5'd0;
    byteSel   = 2'd0;

    // ---- Reset ----
    repeat (3) tick();
    rst = 1'b0;
    check("rst_en",   32'(cpuClkEn),  32'd0);
    check("rst_run",  32'(running),   32'd0);
    check("rst_cnt",  32'(stepCount), 32'd0);
    check("rst_addr", 32'(regAddr),   32'd0);
    check("rst_led",  32'(ledData),   32'd0);

    // ---- Single step: pulse 6..7 cycles after the key edge ----
    btnStep_n = 1'b0;
    first  = -1;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpuClkEn === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("step_pulses",  32'(pulses), 32'd1);
    check("step_latency", 32'(first == 6 || first == 7), 32'd1);
    check("step_count",   32'(stepCount), 32'd1);
    btnStep_n = 1'b1;
    pulses = 0;
    repeat (10) tick_count();
    check("step_release", 32'(pulses), 32'd0);

    // ---- Two-cycle glitches must not step ----
    pulses = 0;
    repeat (2) begin
      btnStep_n = 1'b0;
      repeat (2) tick_count();
      btnStep_n = 1'b1;
      repeat (8) tick_count();
    end
    check("glitch_pulses", 32'(pulses),    32'd0);
    check("glitch_count",  32'(stepCount), 32'd1);

    // ---- RUN at runDivide=2 ----
    runDivide = 4'd2;
    btnMode_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20 && running !== 1'b1; i++) tick_count();
    check("run_enter",   32'(running), 32'd1);
    check("run_nopulse", 32'(pulses),  32'd0);
    btnMode_n = 1'b1;
    base   = int'(stepCount);
    pulses = 0;
    for (int r = 1; r <= 40; r++) begin
      tick_count();
      check("run_tick", 32'(cpuClkEn), 32'(r % 4 == 0));
    end
    check("run_pulses", 32'(pulses), 32'd10);
    k = int'(stepCount) - base;
    check("run_count", 32'(k >= 9 && k <= 11), 32'd1);

    // ---- Back to HALT ----
    btnMode_n = 1'b0;
    for (int i = 0; i < 20 && running !== 1'b0; i++) tick();
    check("halt_enter", 32'(running), 32'd0);
    btnMode_n = 1'b1;
    s = stepCount;
    pulses = 0;
    repeat (20) tick_count();
    check("halt_pulses", 32'(pulses),    32'd0);
    check("halt_count",  32'(stepCount), 32'(s));

    // ---- Simultaneous presses in HALT: RUN only ----
    btnMode_n = 1'b0;
    btnStep_n = 1'b0;
    s = stepCount;
    pulses = 0;
    for (int i = 0; i < 20 && running !== 1'b1; i++) tick_count();
    check("both_run",    32'(running),   32'd1);
    check("both_pulses", 32'(pulses),    32'd0);
    check("both_en",     32'(cpuClkEn),  32'd0);
    check("both_count",  32'(stepCount), 32'(s));
    btnMode_n = 1'b1;
    btnStep_n = 1'b1;

    // ---- runDivide=0: enable held high ----
    runDivide = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("div0_en", 32'(cpuClkEn), 32'd1);
    end

    // ---- stepCount wrap ----
    for (int i = 0; i < 70000 && stepCount !== 16'hFFFE; i++) tick();
    check("wrap_reach", 32'(stepCount), 32'h0000_FFFE);
    tick();
    check("wrap_ffff", 32'(stepCount), 32'h0000_FFFF);
    tick();
    check("wrap_0000", 32'(stepCount), 32'h0000_0000);
    tick();
    check("wrap_0001", 32'(stepCount), 32'h0000_0001);

    // ---- Register view ----
    regSel  = 5'd5;
    byteSel = 2'd0;
    tick();
    check("view_addr",  32'(regAddr), 32'd5);
    check("view_led_1", 32'(ledData), 32'h00);
    tick();
    check("view_b0", 32'(ledData), 32'hD4);
    byteSel = 2'd3;
    tick();
    check("view_b3", 32'(ledData), 32'hA1);
    byteSel = 2'd1;
    tick();
    check("view_b1", 32'(ledData), 32'hC3);
    byteSel = 2'd2;
    tick();
    check("view_b2", 32'(ledData), 32'hB2);
    regSel = 5'd0;
    tick();
    check("view_x0_1", 32'(ledData), 32'hB2);
    tick();
    check("view_x0_2", 32'(ledData), 32'h00);

    // ---- Reset in the middle of continuous pulses ----
    check("mid_pre_en", 32'(cpuClkEn), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_en", 32'(cpuClkEn), 32'd0);
    tick();
    check("mid_en",   32'(cpuClkEn),  32'd0);
    check("mid_run",  32'(running),   32'd0);
    check("mid_cnt",  32'(stepCount), 32'd0);
    check("mid_addr", 32'(regAddr),   32'd0);
    check("mid_led",  32'(ledData),   32'd0);
    rst = 1'b0;
    tick();
    check("mid_after_en", 32'(cpuClkEn), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
